parity_serial_tx: RTL

Bit-serial frame transmitter built around the team's XOR parity function. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per bit_en strobe. It accumulates parity serially and appends it as a final bit. It sits between a word-wide producer and a serial link or test-pattern port, and it sequences the parity datapath.

---
 rtl/parity_pkg.sv | 17 +
 rtl/parity_accum.sv | 35 +++
 rtl/parity_serial_tx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// parity_pkg
// Shared types and constants for the serial parity transmitter.
//   tx_state_t  : frame sequencer states (IDLE, SHIFT, PARITY)
//   PARITY_EVEN : accumulator seed for even parity
//   PARITY_ODD  : accumulator seed for odd parity
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// parity_accum
// One-bit serial XOR accumulator.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset (clears the accumulator)
//   load   : load init into the accumulator (has priority over en)
//   init   : seed value; selects even/odd parity
//   en     : fold din into the accumulator this edge
//   din    : serial data bit
//   parity : current accumulator value
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic init,
    input  logic en,
    input  logic din,
    output logic parity
);

    logic acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= 1'b0;
        end else if (load) begin
            acc_reg <= init;
        end else if (en) begin
            acc_reg <= acc_reg ^ din;
        end
    end

    assign parity = acc_reg;

endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx
// Bit-serial frame transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake, shifts it out LSB first (one bit per bit_en strobe) and
// appends a parity bit. Frame length is WIDTH+1 bit periods.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   in_data    : word to transmit, sampled on accept
//   in_valid   : producer has a word
//   in_ready   : high while idle (decoded from state)
//   bit_en     : bit-period strobe
//   ser_out    : serial data, idles high
//   ser_valid  : high while a data or parity bit is on ser_out
//   parity_out : parity of the last completed frame
//   done       : one-cycle pulse after the parity bit period
module parity_serial_tx
    import parity_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             parity_out,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic PARITY_SEED = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic             ser_out_reg, ser_out_next;
    logic             ser_valid_reg, ser_valid_next;
    logic             parity_out_reg, parity_out_next;
    logic             done_reg, done_next;

    logic             acc_load;
    logic             acc_en;
    logic             acc_parity;

    // The accumulator also folds in the last data bit, so during PARITY it
    // already holds the finished parity bit.
    parity_accum u_accum (
        .clk    (clk),
        .rst    (rst),
        .load   (acc_load),
        .init   (PARITY_SEED),
        .en     (acc_en),
        .din    (sreg_reg[0]),
        .parity (acc_parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sreg_reg       <= '0;
            ser_out_reg    <= 1'b1;
            ser_valid_reg  <= 1'b0;
            parity_out_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sreg_reg       <= sreg_next;
            ser_out_reg    <= ser_out_next;
            ser_valid_reg  <= ser_valid_next;
            parity_out_reg <= parity_out_next;
            done_reg       <= done_next;
        end
    end

    // ser_out is registered, so every transition loads the value that must
    // be visible in the following cycle (the next bit, not the current one).
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        sreg_next       = sreg_reg;
        ser_out_next    = ser_out_reg;
        ser_valid_next  = ser_valid_reg;
        parity_out_next = parity_out_reg;
        done_next       = 1'b0;
        acc_load        = 1'b0;
        acc_en          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sreg_next      = in_data;
                    cnt_next       = '0;
                    acc_load       = 1'b1;
                    ser_out_next   = in_data[0];
                    ser_valid_next = 1'b1;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    acc_en    = 1'b1;
                    sreg_next = sreg_reg >> 1;
                    if (cnt_reg == LAST_CNT) begin
                        cnt_next     = '0;
                        ser_out_next = acc_parity ^ sreg_reg[0];
                        state_next   = PARITY;
                    end else begin
                        cnt_next     = cnt_reg + CNT_W'(1);
                        ser_out_next = sreg_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_en) begin
                    parity_out_next = acc_parity;
                    done_next       = 1'b1;
                    ser_out_next    = 1'b1;
                    ser_valid_next  = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready   = (state_reg == IDLE);
    assign ser_out    = ser_out_reg;
    assign ser_valid  = ser_valid_reg;
    assign parity_out = parity_out_reg;
    assign done       = done_reg;

endmodule
